// File: rtl/alu_md.sv
// MIPS-style ALU with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops respond one cycle after acceptance; MULT*/DIV* take WIDTH+1 cycles.
module alu_md #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SA_W-1:0]  sa,
    input  logic             flush,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned PW   = 2 * WIDTH + 1;
    localparam int unsigned HALF = WIDTH / 2;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_ADDU  = 6'd1;
    localparam logic [5:0] OP_SUBU  = 6'd2;
    localparam logic [5:0] OP_AND   = 6'd3;
    localparam logic [5:0] OP_OR    = 6'd4;
    localparam logic [5:0] OP_SLT   = 6'd5;
    localparam logic [5:0] OP_LUI   = 6'd6;
    localparam logic [5:0] OP_SLL   = 6'd7;
    localparam logic [5:0] OP_SRL   = 6'd8;
    localparam logic [5:0] OP_SRA   = 6'd9;
    localparam logic [5:0] OP_XOR   = 6'd10;
    localparam logic [5:0] OP_NOR   = 6'd11;
    localparam logic [5:0] OP_SLTU  = 6'd12;
    localparam logic [5:0] OP_SUB   = 6'd13;
    localparam logic [5:0] OP_MULT  = 6'd16;
    localparam logic [5:0] OP_MULTU = 6'd17;
    localparam logic [5:0] OP_DIV   = 6'd18;
    localparam logic [5:0] OP_DIVU  = 6'd19;
    localparam logic [5:0] OP_MFHI  = 6'd20;
    localparam logic [5:0] OP_MFLO  = 6'd21;
    localparam logic [5:0] OP_MTHI  = 6'd22;
    localparam logic [5:0] OP_MTLO  = 6'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] hi_q, lo_q, c_q, opnd_q, a_q;
    logic [PW-1:0]    prod_q;
    logic [SA_W-1:0]  cnt_q;
    logic             out_valid_q, ovf_q, zero_q, in_ready_q;
    logic             neg_q, rneg_q, div0_q, eq_q;

    assign c         = c_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign in_ready  = in_ready_q;

    // Single-cycle datapath
    logic [WIDTH-1:0] sum, dif, alu_res;
    logic             alu_ovf;

    always_comb begin
        sum     = a + b;
        dif     = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUBU: alu_res = dif;
            OP_SUB: begin
                alu_res = dif;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_LUI:  alu_res = {b[HALF-1:0], {HALF{1'b0}}};
            OP_SLL:  alu_res = b << sa;
            OP_SRL:  alu_res = b >> sa;
            OP_SRA:  alu_res = WIDTH'($signed(b) >>> sa);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_MTHI: alu_res = a;
            OP_MTLO: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes; signed ops run unsigned and fix signs at the end
    logic             is_signed, a_sgn, b_sgn;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        is_signed = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);
        a_sgn     = is_signed && a[WIDTH-1];
        b_sgn     = is_signed && b[WIDTH-1];
        a_mag     = a_sgn ? -a : a;
        b_mag     = b_sgn ? -b : b;
    end

    // One shift-add / restoring-divide step on the shared product register
    logic [WIDTH:0]     acc_add, shifted, trial;
    logic [2*WIDTH-1:0] mul_step, prod_fin;
    logic [PW-1:0]      div_step;
    logic               div_ok, last_step;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        acc_add   = prod_q[PW-1:WIDTH] + (prod_q[0] ? {1'b0, opnd_q} : '0);
        mul_step  = {acc_add, prod_q[WIDTH-1:1]};
        shifted   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        trial     = shifted - {1'b0, opnd_q};
        div_ok    = ~trial[WIDTH];
        div_step  = {div_ok ? trial : shifted, prod_q[WIDTH-2:0], div_ok};
        prod_fin  = neg_q ? -mul_step : mul_step;
        last_step = (cnt_q == SA_W'(WIDTH - 1));
        res_hi    = '0;
        res_lo    = '0;
        if (state_q == ST_MUL) begin
            res_hi = prod_fin[2*WIDTH-1:WIDTH];
            res_lo = prod_fin[WIDTH-1:0];
        end else if (div0_q) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_hi = rneg_q ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
            res_lo = neg_q  ? -div_step[WIDTH-1:0]       : div_step[WIDTH-1:0];
        end
    end

    // Control FSM, HI/LO and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            c_q         <= '0;
            opnd_q      <= '0;
            a_q         <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            div0_q      <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q && !flush) begin
                        case (alu_ctrl)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state_q    <= (alu_ctrl == OP_MULT || alu_ctrl == OP_MULTU)
                                              ? ST_MUL : ST_DIV;
                                in_ready_q <= 1'b0;
                                cnt_q      <= '0;
                                prod_q     <= {{(WIDTH + 1){1'b0}}, a_mag};
                                opnd_q     <= b_mag;
                                a_q        <= a;
                                neg_q      <= a_sgn ^ b_sgn;
                                rneg_q     <= a_sgn;
                                div0_q     <= (b == '0);
                                eq_q       <= (a == b);
                            end
                            default: begin
                                c_q         <= alu_res;
                                ovf_q       <= alu_ovf;
                                zero_q      <= (a == b);
                                out_valid_q <= 1'b1;
                                if (alu_ctrl == OP_MTHI) hi_q <= a;
                                if (alu_ctrl == OP_MTLO) lo_q <= a;
                            end
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (flush) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        cnt_q      <= '0;
                    end else begin
                        prod_q <= (state_q == ST_MUL) ? {1'b0, mul_step} : div_step;
                        cnt_q  <= cnt_q + SA_W'(1);
                        if (last_step) begin
                            hi_q        <= res_hi;
                            lo_q        <= res_lo;
                            c_q         <= res_lo;
                            ovf_q       <= 1'b0;
                            zero_q      <= eq_q;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_IDLE;
                            in_ready_q  <= 1'b1;
                            cnt_q       <= '0;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md (WIDTH=32) with hand-computed expectations.
module tb_alu_md;

    localparam logic [5:0] OP_ADD = 6'd0,  OP_ADDU = 6'd1,  OP_SUBU = 6'd2,  OP_AND = 6'd3;
    localparam logic [5:0] OP_OR  = 6'd4,  OP_SLT  = 6'd5,  OP_LUI  = 6'd6,  OP_SLL = 6'd7;
    localparam logic [5:0] OP_SRL = 6'd8,  OP_SRA  = 6'd9,  OP_XOR  = 6'd10, OP_NOR = 6'd11;
    localparam logic [5:0] OP_SLTU = 6'd12, OP_SUB = 6'd13, OP_MULT = 6'd16, OP_MULTU = 6'd17;
    localparam logic [5:0] OP_DIV = 6'd18, OP_DIVU = 6'd19, OP_MFHI = 6'd20, OP_MFLO = 6'd21;
    localparam logic [5:0] OP_MTHI = 6'd22, OP_MTLO = 6'd23;

    logic        clk, rst_n, in_valid, in_ready, flush, out_valid, ovf, zero;
    logic [5:0]  alu_ctrl;
    logic [31:0] a, b, c;
    logic [4:0]  sa;

    int n_checks;
    int n_fail;

    alu_md #(.WIDTH(32), .SA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .a(a), .b(b), .sa(sa), .flush(flush),
        .c(c), .out_valid(out_valid), .ovf(ovf), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sav);
        @(negedge clk);
        alu_ctrl = op; a = av; b = bv; sa = sav; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [5:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] sav, input logic [31:0] exp_c,
                        input logic exp_ovf, input logic exp_zero);
        drive(op, av, bv, sav);
        check_eq({tag, "_vld"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_c"}, 64'(c), 64'(exp_c));
        check_eq({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        check_eq({tag, "_zero"}, 64'(zero), 64'(exp_zero));
        check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
    endtask

    task automatic runm(input string tag, input logic [5:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int lat;
        drive(op, av, bv, 5'd0);
        check_eq({tag, "_busy"}, 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'd33);
        check_eq({tag, "_lo"}, 64'(c), 64'(exp_lo));
        check_eq({tag, "_ovf"}, 64'(ovf), 64'd0);
        check_eq({tag, "_zero"}, 64'(zero), 64'(av == bv));
        check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
        run1({tag, "_mfhi"}, OP_MFHI, 32'd0, 32'd0, 5'd0, exp_hi, 1'b0, 1'b1);
        run1({tag, "_mflo"}, OP_MFLO, 32'd0, 32'd0, 5'd0, exp_lo, 1'b0, 1'b1);
    endtask

    initial begin
        int seen;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0;
        alu_ctrl = '0; a = '0; b = '0; sa = '0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_c", 64'(c), 64'd0);
        check_eq("rst_vld", 64'(out_valid), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_zero", 64'(zero), 64'd0);
        check_eq("rst_rdy", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);

        // Request presented with reset release is taken on the first edge
        @(negedge clk);
        rst_n = 1'b1; alu_ctrl = OP_ADD; a = 32'h7FFF_FFFF; b = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("add_ovf_vld", 64'(out_valid), 64'd1);
        check_eq("add_ovf_c", 64'(c), 64'h8000_0000);
        check_eq("add_ovf_ovf", 64'(ovf), 64'd1);

        run1("addu",  OP_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1'b0);
        run1("add_m1", OP_ADD, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0, 1'b0);
        run1("add_neg", OP_ADD, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'h0, 1'b1, 1'b1);
        run1("sub",   OP_SUB,  32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run1("subu",  OP_SUBU, 32'd5, 32'd5, 5'd0, 32'h0, 1'b0, 1'b1);
        run1("slt",   OP_SLT,  32'hFFFF_FFFF, 32'd0, 5'd0, 32'd1, 1'b0, 1'b0);
        run1("sltu",  OP_SLTU, 32'hFFFF_FFFF, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        run1("and",   OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0);
        run1("or",    OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b0, 1'b0);
        run1("xor",   OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 1'b0, 1'b0);
        run1("nor",   OP_NOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h000F_000F, 1'b0, 1'b0);
        run1("lui",   OP_LUI,  32'd0, 32'hABCD_1234, 5'd0, 32'h1234_0000, 1'b0, 1'b0);
        run1("undef", 6'd14,   32'd3, 32'd3, 5'd0, 32'h0, 1'b0, 1'b1);
        run1("sll",   OP_SLL,  32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
        run1("srl",   OP_SRL,  32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0);
        run1("sra",   OP_SRA,  32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0);

        runm("mult",   OP_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
        runm("multu",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        runm("div",    OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        runm("divu0",  OP_DIVU,  32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
        runm("div0",   OP_DIV,   32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
        runm("divmin", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        runm("divpn",  OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);

        // Flush an in-flight MULTU: no pulse, HI/LO keep the prior DIV result
        drive(OP_MULTU, 32'd3, 32'd4, 5'd0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_vld", 64'(out_valid), 64'd0);
        check_eq("flush_rdy", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check_eq("flush_nopulse", 64'(seen), 64'd0);
        run1("flush_mflo", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b1);
        run1("flush_mfhi", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd1, 1'b0, 1'b1);

        // Flush beats a simultaneous request
        @(negedge clk);
        alu_ctrl = OP_MTLO; a = 32'h0000_AAAA; b = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check_eq("flush_req_vld", 64'(out_valid), 64'd0);
        run1("flush_req_mflo", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b1);

        run1("mthi", OP_MTHI, 32'h0000_0055, 32'd0, 5'd0, 32'h55, 1'b0, 1'b0);
        run1("mfhi", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'h55, 1'b0, 1'b1);
        run1("mtlo", OP_MTLO, 32'h0000_0077, 32'd0, 5'd0, 32'h77, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a DIV
        drive(OP_DIV, 32'd100, 32'd7, 5'd0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_c", 64'(c), 64'd0);
        check_eq("arst_vld", 64'(out_valid), 64'd0);
        check_eq("arst_ovf", 64'(ovf), 64'd0);
        check_eq("arst_zero", 64'(zero), 64'd0);
        check_eq("arst_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run1("arst_mfhi", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
        run1("arst_mflo", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64, even).
REQ-002 SHALL have parameter SA_W, default 5, shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at a clock edge.
REQ-007 SHALL have port alu_ctrl  input  6  operation code.
REQ-008 SHALL have ports a, b  input  WIDTH  operands (a = rs, b = rt/immediate).
REQ-009 SHALL have port sa  input  SA_W  shift amount.
REQ-010 SHALL have port flush  input  1  abort the operation in flight.
REQ-011 SHALL have port c  output  WIDTH  registered result.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse marking c, ovf and zero valid.
REQ-013 SHALL have port ovf  output  1  signed overflow of ADD/SUB.
REQ-014 SHALL have port zero  output  1  high when a == b for the accepted operation.

Function
REQ-015 SHALL decode single-cycle ops: 0 ADD, 1 ADDU, 2 SUBU, 3 AND, 4 OR, 5 SLT, 6 LUI, 7 SLL, 8 SRL, 9 SRA, 10 XOR, 11 NOR, 12 SLTU, 13 SUB, 20 MFHI, 21 MFLO, 22 MTHI, 23 MTLO.
REQ-016 SHALL decode multi-cycle ops: 16 MULT, 17 MULTU, 18 DIV, 19 DIVU; undefined codes SHALL produce c=0 with out_valid.
REQ-017 Single-cycle ops SHALL present c/ovf/zero with out_valid exactly 1 cycle after acceptance; in_ready stays high.
REQ-018 LUI SHALL give {b[WIDTH/2-1:0], WIDTH/2 zeros}; shifts SHALL use sa; all add/sub results SHALL wrap modulo 2^WIDTH.
REQ-019 ovf SHALL be high only for ADD/SUB signed overflow; it is 0 for all other ops.
REQ-020 MTHI/MTLO SHALL write a into HI/LO at acceptance, with c = a; MFHI/MFLO SHALL return the current HI/LO.
REQ-021 SHALL implement FSM IDLE, MUL, DIV: MULT*/DIV* accepted in IDLE SHALL enter MUL/DIV; in_ready SHALL be low in MUL/DIV.
REQ-022 MUL SHALL do iterative shift-add, 1 operand bit per cycle, WIDTH cycles; DIV SHALL do restoring division, WIDTH cycles.
REQ-023 On completion, {HI,LO} SHALL update, out_valid SHALL pulse with c = LO, FSM SHALL return to IDLE, and in_ready SHALL rise that same cycle; total latency is WIDTH+1 cycles.
REQ-024 MULT SHALL produce the 2*WIDTH-bit signed product; MULTU the unsigned product; HI = upper half, LO = lower half.
REQ-025 DIV SHALL truncate the quotient toward zero, with the remainder taking the dividend's sign; LO = quotient, HI = remainder.
REQ-026 Divide by zero SHALL give LO = all ones and HI = a, for DIV and DIVU, and SHALL take full latency.
REQ-027 DIV of most-negative by -1 SHALL give LO = most-negative and HI = 0.
REQ-028 flush SHALL return MUL/DIV to IDLE next edge without out_valid or HI/LO change; flush in IDLE SHALL suppress the pending single-cycle out_valid.
REQ-029 flush and in_valid on the same edge: the flush SHALL win and no request SHALL be accepted.

Reset
REQ-030 rst_n low SHALL immediately force FSM=IDLE, HI=LO=0, c=0, out_valid=0, ovf=0, zero=0, in_ready=1, counters 0, including mid-operation.
REQ-031 After rst_n release, the first request SHALL be accepted on the first rising edge.

Verification
REQ-032 ADD a=0x7FFFFFFF b=1 -> next cycle c=0x80000000, ovf=1, out_valid=1; ADDU same operands -> ovf=0.
REQ-033 MULT a=0xFFFFFFFD b=5 -> out_valid 33 cycles later, c=0xFFFFFFF1; MFHI -> 0xFFFFFFFF.
REQ-034 DIV a=0xFFFFFFF9 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=0x1234 b=0 -> LO=0xFFFFFFFF, HI=0x1234.
REQ-035 MULTU then flush at cycle 10 -> no out_valid, in_ready high next cycle, MFLO returns the prior LO.
REQ-036 rst_n pulsed low during DIV cycle 5 -> all outputs 0 asynchronously, in_ready=1, MFHI afterwards -> 0.
REQ-037 SUB a=0x80000000 b=1 -> c=0x7FFFFFFF, ovf=1; SLT a=0xFFFFFFFF b=0 -> c=1; SLTU the same operands -> c=0, zero=0.
